seq_mult_div: RTL and testbench

Iterative signed multiply/divide unit feeding the HI and LO registers of the multicycle datapath. It replaces the combinational Mult and Div blocks plus the DivMult select. The control unit pulses start from its MULT/DIV state, waits in a wait state until done, then asserts HIWrite/LOWrite. One radix-2 iteration per clock: a shared 64-bit accumulator holds partial product or remainder:quotient.

---
 rtl/seq_mult_div_if.sv | 34 +++
 rtl/seq_mult_div.sv | 196 +++++++++++++++++++
 tb/tb_seq_mult_div.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/seq_mult_div_if.sv
// seq_mult_div_if -- handshake/operand/result bundle for the iterative
// multiply/divide unit.
//   start         : begin an operation (sampled only while the unit is idle)
//   op[1:0]       : op[0] 0=mult 1=div; op[1] unsigned select (optional build)
//   a, b          : multiplicand/dividend, multiplier/divisor
//   busy, done    : unit occupied / one-cycle completion pulse
//   hi, lo        : mult {hi,lo}=product; div hi=remainder lo=quotient
//   mult_overflow : product does not fit in lo as a signed (or unsigned) value
//   div_by_zero   : divide issued with b == 0
// The master modport is the requester (control unit); the slave is the unit.
interface seq_mult_div_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             mult_overflow;
  logic             div_by_zero;

  modport master (
    output start, op, a, b,
    input  busy, done, hi, lo, mult_overflow, div_by_zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, hi, lo, mult_overflow, div_by_zero
  );
endinterface

// File: rtl/seq_mult_div.sv
// seq_mult_div -- iterative radix-2 signed multiply / restoring divide unit
// feeding the HI/LO registers. One iteration per clock over a shared
// 2*WIDTH accumulator (partial product, or remainder:quotient).
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-low
//   bus   : seq_mult_div_if.slave (start/op/a/b in, busy/done/hi/lo/flags out)
// Parameters:
//   WIDTH : operand/result width, also the iteration count
//   CNT_W : iteration counter width, 2**CNT_W > WIDTH
// Build option:
//   UNSIGNED_OPS_EN : when defined, op[1]=1 selects multu/divu. When not
//                     defined op[1] is ignored and every op is signed.
module seq_mult_div #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic          clk,
  input  logic          reset,
  seq_mult_div_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;     // |b|: addend for mult, divisor for div
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               ovf_q, ovf_d;
  logic               dbz_q, dbz_d;
  logic               is_div_q, is_div_d;
  logic               sa_q, sa_d;       // a was negative (signed ops only)
  logic               sb_q, sb_d;       // b was negative (signed ops only)

  // ---------------- operand preparation (IDLE) ----------------
  logic             signed_op;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

`ifdef UNSIGNED_OPS_EN
  logic uns_q, uns_d;
  assign signed_op = ~bus.op[1];
`else
  // op[1] has no meaning in this build.
  logic unused_op1;
  assign unused_op1 = bus.op[1];
  assign signed_op  = 1'b1;
`endif

  assign a_neg = signed_op & bus.a[WIDTH-1];
  assign b_neg = signed_op & bus.b[WIDTH-1];
  assign a_mag = a_neg ? (~bus.a + 1'b1) : bus.a;
  assign b_mag = b_neg ? (~bus.b + 1'b1) : bus.b;

  // ---------------- one iteration ----------------
  // Mult: right-shift shift-add; low half holds the remaining multiplier
  // bits of |a|, the sum keeps its carry as the new top bit.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_nx;
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, dvs_q} : '0);
  assign mul_nx  = {mul_sum, acc_q[WIDTH-1:1]};

  // Div: restoring step. The shifted remainder needs WIDTH+1 bits because an
  // unsigned divisor may be as large as 2**WIDTH-1.
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH+1:0]   dif;
  logic               ge;
  logic [2*WIDTH-1:0] div_nx;
  assign rem_sh = acc_q[2*WIDTH-1:WIDTH-1];
  assign dif    = {1'b0, rem_sh} - {2'b00, dvs_q};
  assign ge     = ~dif[WIDTH+1];
  assign div_nx = {(ge ? dif[WIDTH-1:0] : rem_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], ge};

  logic [2*WIDTH-1:0] acc_nx;
  assign acc_nx = is_div_q ? div_nx : mul_nx;

  // ---------------- final sign correction ----------------
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;
  logic [WIDTH-1:0]   res_hi, res_lo;
  logic               res_ovf;
  logic               uns_now;

`ifdef UNSIGNED_OPS_EN
  assign uns_now = uns_q;
`else
  assign uns_now = 1'b0;
`endif

  assign prod   = (sa_q ^ sb_q) ? (~acc_nx + 1'b1) : acc_nx;
  assign quo    = acc_nx[WIDTH-1:0];
  assign rem    = acc_nx[2*WIDTH-1:WIDTH];
  // Remainder follows the dividend's sign so that a == q*b + r.
  assign res_hi = is_div_q ? (sa_q ? (~rem + 1'b1) : rem) : prod[2*WIDTH-1:WIDTH];
  assign res_lo = is_div_q ? ((sa_q ^ sb_q) ? (~quo + 1'b1) : quo) : prod[WIDTH-1:0];
  assign res_ovf = ~is_div_q &
                   (uns_now ? (|res_hi) : (res_hi != {WIDTH{res_lo[WIDTH-1]}}));

  // ---------------- next state / datapath control ----------------
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    dvs_d    = dvs_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    ovf_d    = ovf_q;
    dbz_d    = dbz_q;
    is_div_d = is_div_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
`ifdef UNSIGNED_OPS_EN
    uns_d    = uns_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          acc_d    = {{WIDTH{1'b0}}, a_mag};
          dvs_d    = b_mag;
          cnt_d    = '0;
          is_div_d = bus.op[0];
          sa_d     = a_neg;
          sb_d     = b_neg;
`ifdef UNSIGNED_OPS_EN
          uns_d    = bus.op[1];
`endif
          ovf_d    = 1'b0;
          // Divide by zero skips the iterations; it still spends one CALC
          // cycle so done lands one edge later, and hi/lo are left alone.
          dbz_d    = bus.op[0] && (bus.b == '0);
          state_d  = S_CALC;
        end
      end
      S_CALC: begin
        if (dbz_q) begin
          state_d = S_DONE;
        end else begin
          acc_d = acc_nx;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            hi_d    = res_hi;
            lo_d    = res_lo;
            ovf_d   = res_ovf;
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      ovf_q    <= 1'b0;
      dbz_q    <= 1'b0;
      is_div_q <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
`ifdef UNSIGNED_OPS_EN
      uns_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      dvs_q    <= dvs_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      ovf_q    <= ovf_d;
      dbz_q    <= dbz_d;
      is_div_q <= is_div_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
`ifdef UNSIGNED_OPS_EN
      uns_q    <= uns_d;
`endif
    end
  end

  assign bus.busy          = (state_q != S_IDLE);
  assign bus.done          = (state_q == S_DONE);
  assign bus.hi            = hi_q;
  assign bus.lo            = lo_q;
  assign bus.mult_overflow = ovf_q;
  assign bus.div_by_zero   = dbz_q;

endmodule

// File: tb/tb_seq_mult_div.sv
// tb_seq_mult_div -- directed + random checks of seq_mult_div against a
// plain-arithmetic reference model (64-bit integer multiply/divide).
module tb_seq_mult_div;
  localparam int W = 32;

  logic clk;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  seq_mult_div_if #(.WIDTH(W)) bus ();

  seq_mult_div #(.WIDTH(W), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference results (architectural HI/LO and flags)
  logic [W-1:0] m_hi, m_lo;
  logic         m_ovf, m_dbz;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic        uns;
    longint      sa, sb, q, r;
    logic [63:0] p;
    uns = 1'b0;
`ifdef UNSIGNED_OPS_EN
    uns = op[1];
`endif
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    m_ovf = 1'b0;
    m_dbz = 1'b0;
    if (op[0]) begin
      if (b == '0) m_dbz = 1'b1;            // hi/lo untouched
      else if (uns) begin
        m_lo = a / b;
        m_hi = a % b;
      end else begin
        q = sa / sb;                         // truncates toward zero
        r = sa % sb;                         // sign of dividend
        m_lo = q[31:0];
        m_hi = r[31:0];
      end
    end else begin
      if (uns) p = {32'b0, a} * {32'b0, b};
      else begin
        q = sa * sb;
        p = q;
      end
      m_hi  = p[63:32];
      m_lo  = p[31:0];
      m_ovf = uns ? (m_hi != 0) : ($signed(p) != longint'($signed(m_lo)));
    end
  endtask

  // Issue one op at E0, return number of edges until done is seen.
  task automatic do_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int lat);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    bus.start = 1'b0;
    while (!bus.done && lat < 100) begin
      @(posedge clk); lat++; @(negedge clk);
    end
  endtask

  task automatic run_check(input string tag, input logic [1:0] op,
                           input logic [W-1:0] a, input logic [W-1:0] b);
    int lat, exp_lat;
    model_op(op, a, b);
    exp_lat = m_dbz ? 1 : W;
    do_op(op, a, b, lat);
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_hi"},  64'(bus.hi), 64'(m_hi));
    chk({tag, "_lo"},  64'(bus.lo), 64'(m_lo));
    chk({tag, "_ovf"}, 64'(bus.mult_overflow), 64'(m_ovf));
    chk({tag, "_dbz"}, 64'(bus.div_by_zero), 64'(m_dbz));
    @(negedge clk);
    chk({tag, "_pulse"}, {62'b0, bus.done, bus.busy}, 64'd0);
    chk({tag, "_hold"},  {bus.hi, bus.lo}, {m_hi, m_lo});
  endtask

  initial begin
    int lat;
    logic [W-1:0] ra, rb;
    logic [1:0]   rop;
    bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_hilo", {bus.hi, bus.lo}, 64'd0);
    chk("rst_flags", {62'b0, bus.mult_overflow, bus.div_by_zero}, 64'd0);
    reset = 1'b1;
    m_hi = '0; m_lo = '0;

    // Directed cases from the plan
    run_check("mul_7xm3",   2'b00, 32'd7, 32'hFFFF_FFFD);
    chk("mul_7xm3_hi_const", 64'(bus.hi), 64'hFFFF_FFFF);
    chk("mul_7xm3_lo_const", 64'(bus.lo), 64'hFFFF_FFEB);
    run_check("mul_ovf",    2'b00, 32'h0001_0000, 32'h0001_0000);
    chk("mul_ovf_flag_const", 64'(bus.mult_overflow), 64'd1);
    run_check("div_m7_2",   2'b01, 32'hFFFF_FFF9, 32'd2);
    chk("div_m7_2_const", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_check("div_wrap",   2'b01, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("div_wrap_const", {bus.hi, bus.lo}, 64'h0000_0000_8000_0000);
    run_check("div_preload", 2'b01, 32'h451, 32'h20);      // q=0x22 r=0x11
    run_check("div_zero",   2'b01, 32'd5, 32'd0);
    chk("div_zero_const", {bus.hi, bus.lo}, 64'h0000_0011_0000_0022);

    // Start pulsed mid-operation must be ignored
    model_op(2'b00, 32'h1234_5678, 32'h8765_4321);
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'h1234_5678; bus.b = 32'h8765_4321;
    @(posedge clk);
    lat = 0;
    @(negedge clk); bus.start = 1'b0;
    while (!bus.done && lat < 100) begin
      @(posedge clk); lat++; @(negedge clk);
      if (lat == 10) begin
        bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'd99; bus.b = 32'd0;
      end else bus.start = 1'b0;
    end
    chk("ign_lat", 64'(lat), 64'd32);
    chk("ign_res", {bus.hi, bus.lo}, {m_hi, m_lo});
    chk("ign_dbz", 64'(bus.div_by_zero), 64'd0);
    @(negedge clk);

    // Reset mid-divide clears everything immediately
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'd1000; bus.b = 32'd7;
    @(negedge clk); bus.start = 1'b0;
    repeat (14) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("amid_busy", {62'b0, bus.busy, bus.done}, 64'd0);
    chk("amid_hilo", {bus.hi, bus.lo}, 64'd0);
    chk("amid_flags", {62'b0, bus.mult_overflow, bus.div_by_zero}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    m_hi = '0; m_lo = '0;
    run_check("mul_3x4", 2'b00, 32'd3, 32'd4);
    chk("mul_3x4_const", {bus.hi, bus.lo}, 64'd12);

`ifdef UNSIGNED_OPS_EN
    run_check("multu", 2'b10, 32'hFFFF_FFFF, 32'd2);
    chk("multu_const", {bus.hi, bus.lo}, 64'h0000_0001_FFFF_FFFE);
    run_check("divu",  2'b11, 32'hFFFF_FFFF, 32'd2);
    chk("divu_const", {bus.hi, bus.lo}, 64'h0000_0001_7FFF_FFFF);
    run_check("divu0", 2'b11, 32'd9, 32'd0);
`endif

    // Random ops, with corner operands mixed in
    for (int i = 0; i < 24; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 5))
        0: rb = '0;
        1: rb = 32'($urandom_range(1, 20));
        2: ra = 32'h8000_0000;
        3: rb = 32'hFFFF_FFFF;
        default: ;
      endcase
      run_check($sformatf("rnd%0d", i), rop, ra, rb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute watchdog
  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog timeout got=running exp=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end
endmodule
